// File: rtl/stream_splitter_pkg.sv
// Shared definitions for the word-to-lane serializer: FSM states, counter width
// and the lane-count derivation used by the top and the lane multiplexer.
package stream_splitter_pkg;

   localparam int CNT_W = 16;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } state_e;

   function automatic int num_lanes(input int word_w, input int lane_w);
      return word_w / lane_w;
   endfunction

endpackage

// File: rtl/stream_splitter_lane_mux.sv
// Combinational lane selector: picks lane k of a word, where k counts from the
// top lane when msb_first_i is set and from the bottom lane otherwise.
module lane_mux
   import stream_splitter_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int LANE_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic [WORD_W-1:0] word_i,
   input  logic [IDX_W-1:0]  idx_i,
   input  logic              msb_first_i,
   output logic [LANE_W-1:0] lane_o
);

   localparam int NL = num_lanes(WORD_W, LANE_W);

   int sel;

   always_comb begin
      sel    = msb_first_i ? (NL - 1 - int'(idx_i)) : int'(idx_i);
      lane_o = '0;
      for (int k = 0; k < NL; k++) begin
         if (k == sel) lane_o = word_i[k*LANE_W +: LANE_W];
      end
   end

endmodule

// File: rtl/stream_splitter.sv
// Word-to-lane serializer: takes one word per input handshake and emits its lanes
// one per output handshake, reloading during the final lane so words stream gap-free.
module stream_splitter
   import stream_splitter_pkg::*;
#(
   parameter int WORD_W = 32,
   parameter int LANE_W = 8,
   parameter int IDX_W  = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WORD_W-1:0] in_data,
   input  logic              in_msb_first,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [LANE_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_last,
   output logic [CNT_W-1:0]  words_done
);

   localparam int NL = num_lanes(WORD_W, LANE_W);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NL - 1);

   if (WORD_W % LANE_W != 0) begin : g_bad_ratio
      $error("stream_splitter: WORD_W must be a multiple of LANE_W");
   end
   if (NL < 2) begin : g_too_few_lanes
      $error("stream_splitter: WORD_W/LANE_W must be at least 2");
   end
   if ((1 << IDX_W) < NL) begin : g_idx_too_narrow
      $error("stream_splitter: IDX_W too narrow for lane count");
   end

   state_e              state_q;
   logic [WORD_W-1:0]   word_q;
   logic                msb_q;
   logic [IDX_W-1:0]    idx_q;
   logic                out_valid_q;
   logic [LANE_W-1:0]   out_data_q;
   logic [CNT_W-1:0]    words_q;

   logic                out_fire;
   logic                in_fire;
   logic [WORD_W-1:0]   word_d;
   logic [IDX_W-1:0]    idx_d;
   logic                msb_d;
   logic [LANE_W-1:0]   lane_d;

   assign out_last   = out_valid_q & (idx_q == IDX_LAST);
   assign out_fire   = out_valid_q & out_ready;
   assign in_ready   = (state_q == S_IDLE) | (out_fire & out_last);
   assign in_fire    = in_valid & in_ready;

   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_idx    = idx_q;
   assign words_done = words_q;

   // A fresh word selects its first lane; otherwise advance within the held word.
   always_comb begin
      word_d = word_q;
      idx_d  = idx_q + 1'b1;
      msb_d  = msb_q;
      if (in_fire) begin
         word_d = in_data;
         idx_d  = '0;
         msb_d  = in_msb_first;
      end
   end

   lane_mux #(
      .WORD_W (WORD_W),
      .LANE_W (LANE_W),
      .IDX_W  (IDX_W)
   ) u_lane_mux (
      .word_i      (word_d),
      .idx_i       (idx_d),
      .msb_first_i (msb_d),
      .lane_o      (lane_d)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         word_q      <= '0;
         msb_q       <= 1'b0;
         idx_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         words_q     <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_fire) begin
                  word_q      <= word_d;
                  msb_q       <= msb_d;
                  idx_q       <= idx_d;
                  out_data_q  <= lane_d;
                  out_valid_q <= 1'b1;
                  state_q     <= S_SEND;
               end
            end
            S_SEND: begin
               if (out_fire) begin
                  if (!out_last) begin
                     idx_q      <= idx_d;
                     out_data_q <= lane_d;
                  end else begin
                     words_q <= words_q + 1'b1;
                     if (in_fire) begin
                        word_q     <= word_d;
                        msb_q      <= msb_d;
                        idx_q      <= idx_d;
                        out_data_q <= lane_d;
                     end else begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stream_splitter.sv
// Bench for stream_splitter: directed scenarios plus randomized handshakes scored
// against a lane-queue model; a second 48/12 instance covers wide lanes and counter wrap.
module tb_stream_splitter;

   localparam int WW  = 32;
   localparam int LW  = 8;
   localparam int IW  = 2;
   localparam int NL  = WW / LW;
   localparam int WW2 = 48;
   localparam int LW2 = 12;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [WW-1:0] in_data = '0;
   logic          in_msb_first = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [LW-1:0] out_data;
   logic [IW-1:0] out_idx;
   logic          out_last;
   logic [15:0]   words_done;

   logic           in_valid2 = 1'b0;
   logic           in_ready2;
   logic [WW2-1:0] in_data2 = '0;
   logic           in_msb_first2 = 1'b0;
   logic           out_valid2;
   logic           out_ready2 = 1'b0;
   logic [LW2-1:0] out_data2;
   logic [IW-1:0]  out_idx2;
   logic           out_last2;
   logic [15:0]    words_done2;

   int n_tests = 0;
   int n_fail  = 0;

   stream_splitter #(.WORD_W(WW), .LANE_W(LW), .IDX_W(IW)) u_dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_msb_first(in_msb_first), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
      .out_last(out_last), .words_done(words_done)
   );

   stream_splitter #(.WORD_W(WW2), .LANE_W(LW2), .IDX_W(IW)) u_dut48 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data2), .in_msb_first(in_msb_first2), .out_valid(out_valid2),
      .out_ready(out_ready2), .out_data(out_data2), .out_idx(out_idx2),
      .out_last(out_last2), .words_done(words_done2)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_lane(input string tag, input logic [7:0] d, input int idx, input bit last);
      check({tag, "_valid"}, out_valid, 1'b1);
      check({tag, "_data"}, out_data, d);
      check({tag, "_idx"}, out_idx, idx);
      check({tag, "_last"}, out_last, last);
   endtask

   // Reference model: every accepted word becomes NL queued lanes in emission order.
   typedef struct {
      logic [LW-1:0] data;
      int            idx;
      bit            last;
   } lane_t;

   lane_t       q[$];
   logic [15:0] words_exp = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         words_exp = '0;
      end else begin
         check("m_out_valid", out_valid, q.size() > 0);
         check("m_words_done", words_done, words_exp);
         check("m_in_ready", in_ready, (q.size() == 0) || (out_ready && q.size() == 1));
         if (out_valid && q.size() > 0) begin
            check("m_out_data", out_data, q[0].data);
            check("m_out_idx", out_idx, q[0].idx);
            check("m_out_last", out_last, q[0].last);
         end
         if (out_valid && out_ready && q.size() > 0) begin
            if (q[0].last) words_exp = words_exp + 16'd1;
            void'(q.pop_front());
         end
         if (in_valid && in_ready) begin
            for (int k = 0; k < NL; k++) begin
               lane_t e;
               int    pos;
               pos    = in_msb_first ? (NL - 1 - k) : k;
               e.data = LW'(in_data >> (pos * LW));
               e.idx  = k;
               e.last = (k == NL - 1);
               q.push_back(e);
            end
         end
      end
   end

   logic [7:0]  exp2 [4]  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0};
   logic [7:0]  exp3a [4] = '{8'hF0, 8'hF8, 8'hFC, 8'hFE};
   logic [7:0]  exp3b [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
   logic [11:0] exp6m [4] = '{12'hABC, 12'hDEF, 12'h123, 12'h456};
   logic [11:0] exp6l [4] = '{12'h456, 12'h123, 12'hDEF, 12'hABC};

   initial begin
      bit accepted;

      // Reset with a pending word: nothing may be captured.
      in_valid  = 1'b1;
      in_data   = 32'hDEAD_BEEF;
      out_ready = 1'b1;
      repeat (3) tick();
      check("t1_out_valid", out_valid, 1'b0);
      check("t1_out_data", out_data, 8'h00);
      check("t1_out_idx", out_idx, 2'd0);
      check("t1_out_last", out_last, 1'b0);
      check("t1_words", words_done, 16'd0);
      check("t1_in_ready", in_ready, 1'b1);
      in_valid = 1'b0;
      rst_n    = 1'b1;
      tick();
      check("t1_no_capture", out_valid, 1'b0);

      // MSB-first word.
      in_valid = 1'b1; in_data = 32'hFEFC_F8F0; in_msb_first = 1'b1; out_ready = 1'b1;
      check("t2_in_ready", in_ready, 1'b1);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_lane("t2", exp2[i], i, i == 3);
         tick();
      end
      check("t2_idle", out_valid, 1'b0);
      check("t2_words", words_done, 16'd1);

      // LSB-first word, then a back-to-back word offered during the last lane.
      in_valid = 1'b1; in_data = 32'hFEFC_F8F0; in_msb_first = 1'b0;
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         expect_lane("t3a", exp3a[i], i, i == 3);
         if (i == 3) begin
            in_valid = 1'b1; in_data = 32'h0403_0201; in_msb_first = 1'b0;
            check("t3_in_ready_last", in_ready, 1'b1);
         end
         tick();
      end
      in_valid = 1'b0;
      in_msb_first = 1'b1;
      for (int i = 0; i < 4; i++) begin
         expect_lane("t3b", exp3b[i], i, i == 3);
         tick();
      end
      check("t3_words", words_done, 16'd3);

      // Backpressure on lane 1.
      in_valid = 1'b1; in_data = 32'h1122_3344; in_msb_first = 1'b1;
      tick();
      in_valid = 1'b0;
      expect_lane("t4_l0", 8'h11, 0, 1'b0);
      tick();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         expect_lane("t4_hold", 8'h22, 1, 1'b0);
         check("t4_in_ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      expect_lane("t4_l2", 8'h33, 2, 1'b0);
      tick();
      expect_lane("t4_l3", 8'h44, 3, 1'b1);
      tick();
      check("t4_words", words_done, 16'd4);

      // Reset in the middle of a word.
      in_valid = 1'b1; in_data = 32'hAABB_CCDD; in_msb_first = 1'b1;
      tick();
      in_valid = 1'b0;
      expect_lane("t5_l0", 8'hAA, 0, 1'b0);
      tick();
      expect_lane("t5_l1", 8'hBB, 1, 1'b0);
      #1 rst_n = 1'b0;
      #1;
      check("t5_out_valid", out_valid, 1'b0);
      check("t5_out_data", out_data, 8'h00);
      check("t5_out_idx", out_idx, 2'd0);
      check("t5_words", words_done, 16'd0);
      check("t5_in_ready", in_ready, 1'b1);
      in_valid = 1'b1; in_data = 32'h0102_0304; in_msb_first = 1'b0;
      tick();
      check("t5_no_capture", out_valid, 1'b0);
      rst_n = 1'b1;
      tick();
      in_valid = 1'b0;
      expect_lane("t5_restart", 8'h04, 0, 1'b0);
      repeat (4) tick();
      check("t5_words_after", words_done, 16'd1);

      // Randomized traffic scored by the model.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         accepted = in_valid && in_ready;
         tick();
         if (!in_valid || accepted) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = $urandom;
         end
         in_msb_first = $urandom_range(0, 1) == 1;
         out_ready    = ($urandom_range(0, 3) != 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         if (!out_valid) break;
         tick();
      end
      check("drain_idle", out_valid, 1'b0);
      check("drain_queue_empty", q.size(), 0);

      // Wide-lane instance: 48-bit word, 12-bit lanes.
      in_valid2 = 1'b1; in_data2 = 48'hABC_DEF_123_456; in_msb_first2 = 1'b1; out_ready2 = 1'b1;
      tick();
      in_valid2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t6m_valid", out_valid2, 1'b1);
         check("t6m_data", out_data2, exp6m[i]);
         check("t6m_idx", out_idx2, i);
         check("t6m_last", out_last2, i == 3);
         tick();
      end
      check("t6_words", words_done2, 16'd1);

      // Counter wrap: preload the count to its maximum, then finish one more word.
      force u_dut48.words_q = 16'hFFFF;
      #1;
      release u_dut48.words_q;
      check("t6_preload", words_done2, 16'hFFFF);
      in_valid2 = 1'b1; in_msb_first2 = 1'b0;
      tick();
      in_valid2 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check("t6l_data", out_data2, exp6l[i]);
         check("t6l_idx", out_idx2, i);
         tick();
      end
      check("t6_wrap", words_done2, 16'd0);
      check("t6_idle", out_valid2, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
